// File: rtl/mdio_pkg.sv
// Shared encodings for the clause-22 MDIO sequencer: state names, frame opcodes
// and field widths, plus the 64-bit frame builder used at grant.
package mdio_pkg;

   typedef enum logic [2:0] {
      IDLE, PRE, HDR, TA, DATA, DONE, GAP
   } mdio_state_t;

   localparam logic [1:0] OP_WR = 2'b01;
   localparam logic [1:0] OP_RD = 2'b10;
   localparam logic [1:0] ST    = 2'b01;

   localparam int PHY_W   = 5;
   localparam int REG_W   = 5;
   localparam int DATA_W  = 16;
   localparam int PRE_LEN = 32;

   // Bit indices (MSB first, 63 down to 0) where each field begins.
   localparam logic [5:0] HDR_TOP  = 6'd31;
   localparam logic [5:0] TA_TOP   = 6'd17;
   localparam logic [5:0] DATA_TOP = 6'd15;

   // Read frames carry ones in TA/DATA so mdio_o idles high while released.
   function automatic logic [63:0] build_frame(input logic wr,
                                               input logic [PHY_W-1:0] phy,
                                               input logic [REG_W-1:0] reg_addr,
                                               input logic [DATA_W-1:0] wdata);
      build_frame = {{PRE_LEN{1'b1}}, ST, (wr ? OP_WR : OP_RD), phy, reg_addr,
                     (wr ? 2'b10 : 2'b11), (wr ? wdata : 16'hFFFF)};
   endfunction

   function automatic mdio_state_t field_state(input logic [5:0] idx);
      if (idx > HDR_TOP)       field_state = PRE;
      else if (idx > TA_TOP)   field_state = HDR;
      else if (idx > DATA_TOP) field_state = TA;
      else                     field_state = DATA;
   endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC divider: toggles mdc every CLK_DIV cycles while enabled, parked low otherwise.
// Ticks are asserted in the cycle whose closing edge changes mdc.
module mdio_clk_gen #(
   parameter int CLK_DIV = 25
) (
   input  logic clk_sys,
   input  logic rst,
   input  logic en,
   output logic mdc,
   output logic rise_tick,
   output logic fall_tick
);

   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] LOAD = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;
   logic          term;

   assign term      = (cnt == '0);
   assign rise_tick = en && term && !mdc;
   assign fall_tick = en && term && mdc;

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         cnt <= LOAD;
         mdc <= 1'b0;
      end else if (!en) begin
         cnt <= LOAD;
         mdc <= 1'b0;
      end else if (term) begin
         cnt <= LOAD;
         mdc <= ~mdc;
      end else begin
         cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/mdio_ctrl.sv
// Clause-22 MDIO frame sequencer arbitrating CPU accesses against a periodic
// link-status poll of the PHY.
//
// state | meaning
// IDLE  | waiting; arbitrate cpu_req over poll pending
// PRE   | 32-bit preamble of ones
// HDR   | ST, OP, PHYAD, REGAD (14 bits)
// TA    | turnaround (driven 10 on write, released on read)
// DATA  | 16 data bits (driven on write, sampled on read)
// DONE  | one cycle after last fall; release bus, then report
// GAP   | 2*CLK_DIV idle cycles with mdc low
module mdio_ctrl
   import mdio_pkg::*;
#(
   parameter int         CLK_DIV       = 25,
   parameter int         POLL_INTERVAL = 1000000,
   parameter logic [4:0] POLL_REG      = 5'd1,
   parameter int         LINK_BIT      = 2
) (
   input  logic        clk_sys,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_wr,
   input  logic [4:0]  cpu_phy_addr,
   input  logic [4:0]  cpu_reg_addr,
   input  logic [15:0] cpu_wdata,
   output logic        cpu_ack,
   output logic [15:0] cpu_rdata,
   output logic        cpu_err,
   input  logic        poll_en,
   input  logic [4:0]  poll_phy_addr,
   output logic        link_status,
   output logic        link_valid,
   output logic        busy,
   output logic        mdc,
   output logic        mdio_o,
   output logic        mdio_oe,
   input  logic        mdio_i
);

   localparam int GW = $clog2(2 * CLK_DIV);
   localparam logic [GW-1:0] GAP_LOAD = GW'(2 * CLK_DIV - 1);
   localparam int PW = $clog2(POLL_INTERVAL);
   localparam logic [PW-1:0] POLL_LAST = PW'(POLL_INTERVAL - 1);

   mdio_state_t   state;
   logic [63:0]   frame;
   logic [5:0]    bit_idx;
   logic [5:0]    idx_nxt;
   logic          rd_q;
   logic          poll_q;
   logic          ta_err;
   logic [15:0]   rdata_sh;
   logic [GW-1:0] gap_cnt;
   logic [PW-1:0] poll_cnt;
   logic          poll_pend;
   logic          rise_tick;
   logic          fall_tick;
   logic          grant_cpu;
   logic          grant_poll;
   logic [63:0]   grant_frame;

   mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
      .clk_sys   (clk_sys),
      .rst       (rst),
      .en        (busy),
      .mdc       (mdc),
      .rise_tick (rise_tick),
      .fall_tick (fall_tick)
   );

   assign grant_cpu   = (state == IDLE) && cpu_req;
   assign grant_poll  = (state == IDLE) && !cpu_req && poll_pend;
   assign idx_nxt     = bit_idx - 6'd1;
   assign grant_frame = grant_cpu ? build_frame(cpu_wr, cpu_phy_addr, cpu_reg_addr, cpu_wdata)
                                  : build_frame(1'b0, poll_phy_addr, POLL_REG, 16'h0000);

   // Pending is sticky: a wrap while already pending does not queue a second poll.
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         poll_cnt  <= '0;
         poll_pend <= 1'b0;
      end else if (!poll_en) begin
         poll_cnt  <= '0;
         poll_pend <= 1'b0;
      end else if (poll_cnt == POLL_LAST) begin
         poll_cnt  <= '0;
         poll_pend <= 1'b1;
      end else begin
         poll_cnt <= poll_cnt + 1'b1;
         if (grant_poll) poll_pend <= 1'b0;
      end
   end

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         frame       <= '0;
         bit_idx     <= '0;
         rd_q        <= 1'b0;
         poll_q      <= 1'b0;
         ta_err      <= 1'b0;
         rdata_sh    <= '0;
         gap_cnt     <= '0;
         busy        <= 1'b0;
         mdio_o      <= 1'b1;
         mdio_oe     <= 1'b0;
         cpu_ack     <= 1'b0;
         cpu_err     <= 1'b0;
         cpu_rdata   <= '0;
         link_status <= 1'b0;
         link_valid  <= 1'b0;
      end else begin
         cpu_ack <= 1'b0;
         unique case (state)
            IDLE: begin
               if (grant_cpu || grant_poll) begin
                  state    <= PRE;
                  busy     <= 1'b1;
                  frame    <= grant_frame;
                  bit_idx  <= 6'd63;
                  rd_q     <= grant_poll || !cpu_wr;
                  poll_q   <= grant_poll;
                  ta_err   <= 1'b0;
                  rdata_sh <= '0;
                  mdio_o   <= grant_frame[63];
                  mdio_oe  <= 1'b1;
               end
            end
            PRE, HDR, TA, DATA: begin
               if (rise_tick && rd_q) begin
                  if (bit_idx == 6'd16) ta_err <= mdio_i;
                  if (state == DATA)    rdata_sh <= {rdata_sh[14:0], mdio_i};
               end
               if (fall_tick) begin
                  if (bit_idx == 6'd0) begin
                     state   <= DONE;
                     mdio_o  <= 1'b1;
                     mdio_oe <= 1'b0;
                  end else begin
                     bit_idx <= idx_nxt;
                     state   <= field_state(idx_nxt);
                     mdio_o  <= frame[idx_nxt];
                     mdio_oe <= !rd_q || (idx_nxt > TA_TOP);
                  end
               end
            end
            DONE: begin
               state   <= GAP;
               busy    <= 1'b0;
               gap_cnt <= GAP_LOAD;
               if (poll_q) begin
                  link_valid  <= 1'b1;
                  link_status <= ta_err ? 1'b0 : rdata_sh[LINK_BIT];
               end else begin
                  cpu_ack <= 1'b1;
                  cpu_err <= rd_q && ta_err;
                  if (rd_q) cpu_rdata <= ta_err ? 16'hFFFF : rdata_sh;
               end
            end
            GAP: begin
               if (gap_cnt == '0) state <= IDLE;
               else               gap_cnt <= gap_cnt - 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdio_ctrl.sv
// Self-checking bench for mdio_ctrl: table of CPU frames scored through a queue,
// plus hand sequences for polling, arbitration and mid-frame reset.
module tb_mdio_ctrl;

   localparam int CLK_DIV       = 4;
   localparam int POLL_INTERVAL = 1024;
   localparam int FRAME_CYC     = 128 * CLK_DIV + 1;
   localparam int IDLE_GAP      = 2 * CLK_DIV + 1;

   logic        clk_sys = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_req = 1'b0, cpu_wr = 1'b0;
   logic [4:0]  cpu_phy_addr = '0, cpu_reg_addr = '0;
   logic [15:0] cpu_wdata = '0;
   logic        cpu_ack, cpu_err;
   logic [15:0] cpu_rdata;
   logic        poll_en = 1'b0;
   logic [4:0]  poll_phy_addr = '0;
   logic        link_status, link_valid, busy, mdc, mdio_o, mdio_oe;
   logic        mdio_i;

   mdio_ctrl #(.CLK_DIV(CLK_DIV), .POLL_INTERVAL(POLL_INTERVAL), .POLL_REG(5'd1), .LINK_BIT(2)) dut (
      .clk_sys(clk_sys), .rst(rst), .cpu_req(cpu_req), .cpu_wr(cpu_wr),
      .cpu_phy_addr(cpu_phy_addr), .cpu_reg_addr(cpu_reg_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
      .poll_en(poll_en), .poll_phy_addr(poll_phy_addr),
      .link_status(link_status), .link_valid(link_valid), .busy(busy),
      .mdc(mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe), .mdio_i(mdio_i)
   );

   always #5 clk_sys = ~clk_sys;

   int errors = 0, checks = 0;
   int cyc = 0;
   always @(posedge clk_sys) cyc <= cyc + 1;

   // PHY model: releases the bus (pull-up 1) except TA bit 2 and the read data.
   logic [15:0] phy_resp = '0;
   logic        phy_stuck = 1'b0;
   int          phy_idx = 0;

   function automatic logic phy_bit(input int idx, input logic [15:0] resp, input logic stuck);
      if (stuck || idx < 47 || idx > 63) return 1'b1;
      if (idx == 47) return 1'b0;
      return resp[63 - idx];
   endfunction

   assign mdio_i = phy_bit(phy_idx, phy_resp, phy_stuck);

   // Monitor: grant/ack timestamps, mdc edges, captured bit stream.
   logic        busy_d = 1'b0, mdc_d = 1'b0;
   int          grant_cyc = 0, ack_cyc = 0, grant_cnt = 0, ack_cnt = 0;
   logic [63:0] cap_o = '0, cap_oe = '0;

   always @(posedge clk_sys) begin
      #1;
      if (busy && !busy_d) begin
         grant_cyc = cyc;
         grant_cnt++;
         phy_idx = 0;
         cap_o   = '0;
         cap_oe  = '0;
      end
      if (cpu_ack) begin
         ack_cyc = cyc;
         ack_cnt++;
      end
      if (mdc && !mdc_d) begin
         cap_o  = {cap_o[62:0], mdio_o};
         cap_oe = {cap_oe[62:0], mdio_oe};
      end
      if (!mdc && mdc_d) phy_idx++;
      busy_d = busy;
      mdc_d  = mdc;
   end

   task automatic tick();
      @(posedge clk_sys);
      #2;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] mk_frame(input logic wr, input logic [4:0] phy,
                                            input logic [4:0] ra, input logic [15:0] wd);
      return {32'hFFFF_FFFF, 2'b01, (wr ? 2'b01 : 2'b10), phy, ra,
              (wr ? 2'b10 : 2'b00), (wr ? wd : 16'h0000)};
   endfunction

   function automatic logic [63:0] mk_oe(input logic wr);
      return wr ? {64{1'b1}} : {{46{1'b1}}, 18'h0};
   endfunction

   typedef struct {
      logic        wr;
      logic [4:0]  phy;
      logic [4:0]  ra;
      logic [15:0] wdata;
      logic [15:0] resp;
      logic        stuck;
      logic [15:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [63:0] frame;
      logic [63:0] oe;
      logic [15:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb[$];

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic wait_ack(input string name, input int start, input int bound);
      int t = 0;
      while (ack_cnt == start && t < bound) begin
         tick();
         t++;
      end
      check({name, "_ack_seen"}, 64'(ack_cnt - start), 64'd1);
   endtask

   task automatic run_cpu(input vec_t v, input string name);
      exp_t e;
      int   s;
      phy_resp  = v.resp;
      phy_stuck = v.stuck;
      e.frame = mk_frame(v.wr, v.phy, v.ra, v.wdata);
      e.oe    = mk_oe(v.wr);
      e.rdata = v.exp_rdata;
      e.err   = v.exp_err;
      sb.push_back(e);
      cpu_wr = v.wr; cpu_phy_addr = v.phy; cpu_reg_addr = v.ra; cpu_wdata = v.wdata;
      cpu_req = 1'b1;
      s = ack_cnt;
      wait_ack(name, s, 2000);
      cpu_req = 1'b0;
      e = sb.pop_front();
      check({name, "_frame"}, cap_o & e.oe, e.frame & e.oe);
      check({name, "_oe"}, cap_oe, e.oe);
      check({name, "_latency"}, 64'(ack_cyc - grant_cyc), 64'(FRAME_CYC));
      check({name, "_rdata"}, 64'(cpu_rdata), 64'(e.rdata));
      check({name, "_err"}, 64'(cpu_err), 64'(e.err));
      check({name, "_busy_at_ack"}, 64'(busy), 64'd0);
      tick();
      check({name, "_ack_pulse"}, 64'(cpu_ack), 64'd0);
      repeat (IDLE_GAP + 2) tick();
   endtask

   vec_t vecs[5];

   initial begin
      int          s, g0, t, t0, a1;
      logic [63:0] pf;

      vecs[0] = '{1'b1, 5'd1,  5'd0,  16'h1140, 16'h0000, 1'b0, 16'h0000, 1'b0};
      vecs[1] = '{1'b0, 5'd1,  5'd2,  16'h0000, 16'h0141, 1'b0, 16'h0141, 1'b0};
      vecs[2] = '{1'b0, 5'd1,  5'd3,  16'h0000, 16'h1234, 1'b1, 16'hFFFF, 1'b1};
      vecs[3] = '{1'b1, 5'd31, 5'd31, 16'hA5A5, 16'h0000, 1'b0, 16'hFFFF, 1'b0};
      vecs[4] = '{1'b0, 5'd5,  5'd9,  16'h0000, 16'h8001, 1'b0, 16'h8001, 1'b0};

      tick();
      tick();
      check("rst_mdc", 64'(mdc), 64'd0);
      check("rst_mdio_o", 64'(mdio_o), 64'd1);
      check("rst_oe", 64'(mdio_oe), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_ack_err", 64'({cpu_ack, cpu_err}), 64'd0);
      check("rst_rdata", 64'(cpu_rdata), 64'd0);
      check("rst_link", 64'({link_status, link_valid}), 64'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 5; i++) run_cpu(vecs[i], $sformatf("vec%0d", i));

      // Autonomous poll: first poll after POLL_INTERVAL cycles, no cpu_ack.
      do_reset();
      phy_resp = 16'h796D; phy_stuck = 1'b0; poll_phy_addr = 5'd3;
      s = ack_cnt; g0 = grant_cnt; t0 = cyc;
      poll_en = 1'b1;
      t = 0;
      while (grant_cnt == g0 && t < 1500) begin tick(); t++; end
      check("poll_start_window", 64'((grant_cyc - t0) >= 1023 && (grant_cyc - t0) <= 1026), 64'd1);
      t = 0;
      while (!link_valid && t < 800) begin tick(); t++; end
      pf = mk_frame(1'b0, 5'd3, 5'd1, 16'h0);
      check("poll_header", cap_o >> 18, pf >> 18);
      check("poll_link", 64'({link_status, link_valid}), 64'b11);
      check("poll_no_ack", 64'(ack_cnt - s), 64'd0);
      check("poll_rdata_kept", 64'(cpu_rdata), 64'd0);
      poll_en = 1'b0;
      repeat (20) tick();

      // CPU frame runs while poll becomes pending; cpu_req held through ack wins again.
      do_reset();
      phy_resp = 16'h0000; poll_phy_addr = 5'd7;
      poll_en = 1'b1;
      repeat (600) tick();
      cpu_wr = 1'b1; cpu_phy_addr = 5'd2; cpu_reg_addr = 5'd4; cpu_wdata = 16'hBEEF;
      cpu_req = 1'b1;
      s = ack_cnt;
      wait_ack("prio_cpu1", s, 2000);
      a1 = ack_cyc;
      wait_ack("prio_cpu2", s + 1, 2000);
      cpu_req = 1'b0;
      check("prio_cpu2_gap", 64'(grant_cyc - a1), 64'(IDLE_GAP));
      check("prio_poll_waits", 64'(link_valid), 64'd0);
      g0 = grant_cnt;
      t = 0;
      while (grant_cnt == g0 && t < 100) begin tick(); t++; end
      check("prio_poll_gap", 64'(grant_cyc - ack_cyc), 64'(IDLE_GAP));
      t = 0;
      while (!link_valid && t < 800) begin tick(); t++; end
      check("prio_poll_link", 64'({link_status, link_valid}), 64'b01);
      check("prio_poll_no_ack", 64'(ack_cnt - s), 64'd2);
      poll_en = 1'b0;
      repeat (20) tick();

      // Reset in the middle of the DATA field.
      cpu_wr = 1'b1; cpu_phy_addr = 5'd1; cpu_reg_addr = 5'd0; cpu_wdata = 16'hFFFF;
      g0 = grant_cnt;
      cpu_req = 1'b1;
      t = 0;
      while (grant_cnt == g0 && t < 100) begin tick(); t++; end
      repeat (450) tick();
      check("midrst_in_data", 64'(busy && mdio_oe), 64'd1);
      cpu_req = 1'b0;
      s = ack_cnt;
      rst = 1'b1;
      #1;
      check("midrst_mdc", 64'(mdc), 64'd0);
      check("midrst_oe_o", 64'({mdio_oe, mdio_o}), 64'b01);
      check("midrst_busy", 64'(busy), 64'd0);
      tick();
      rst = 1'b0;
      repeat (600) tick();
      check("midrst_no_ack", 64'(ack_cnt - s), 64'd0);
      run_cpu(vecs[1], "after_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
